// File: rtl/mem_transpose_sched.sv
// Block-level scheduler for the transpose write-address generator: walks the block
// grid in raster order and hands finished blocks to ping-pong banks freed by the consumer.
module mem_transpose_sched #(
    parameter int LOG_B = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LOG_B-1:0] bx_max,
    input  logic [LOG_B-1:0] by_max,
    output logic             blk_vld,
    output logic [LOG_B-1:0] block_x,
    output logic [LOG_B-1:0] block_y,
    input  logic             blk_done,
    output logic             bank_sel,
    output logic             bank_filled,
    output logic             filled_id,
    input  logic [1:0]       bank_release,
    output logic [1:0]       bank_busy,
    output logic             busy,
    output logic             all_done
);

    typedef enum logic [1:0] {IDLE, WAIT_BANK, RUN, FIN} state_t;

    state_t           state, state_n;
    logic [LOG_B-1:0] bx_max_l, by_max_l, bx_max_n, by_max_n;
    logic [LOG_B-1:0] block_x_n, block_y_n, x_inc, y_inc;
    logic             bank_sel_n, bank_filled_n, filled_id_n, all_done_n;
    logic [1:0]       bank_busy_n;
    logic             fill;

    // NOTE: every signal gets its hold/default value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_n       = state;
        bx_max_n      = bx_max_l;
        by_max_n      = by_max_l;
        block_x_n     = block_x;
        block_y_n     = block_y;
        bank_sel_n    = bank_sel;
        filled_id_n   = filled_id;
        bank_filled_n = 1'b0;
        all_done_n    = 1'b0;
        fill          = 1'b0;
        x_inc         = block_x + 1'b1;
        y_inc         = block_y + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    bx_max_n   = bx_max;
                    by_max_n   = by_max;
                    block_x_n  = '0;
                    block_y_n  = '0;
                    bank_sel_n = 1'b0;
                    state_n    = (bx_max == '0 || by_max == '0) ? FIN : WAIT_BANK;
                end
            end
            WAIT_BANK: begin
                if (!bank_busy[bank_sel]) state_n = RUN;
            end
            RUN: begin
                if (blk_done) begin
                    fill          = 1'b1;
                    bank_filled_n = 1'b1;
                    filled_id_n   = bank_sel;
                    bank_sel_n    = ~bank_sel;
                    state_n       = WAIT_BANK;
                    if (x_inc == bx_max_l) begin
                        block_x_n = '0;
                        if (y_inc == by_max_l) begin
                            block_y_n = '0;
                            state_n   = FIN;
                        end else begin
                            block_y_n = y_inc;
                        end
                    end else begin
                        block_x_n = x_inc;
                    end
                end
            end
            FIN: begin
                all_done_n = 1'b1;
                block_x_n  = '0;
                block_y_n  = '0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A fill of a bank overrides a simultaneous release of that same bank.
        bank_busy_n[0] = (fill && !bank_sel) ? 1'b1 : (bank_release[0] ? 1'b0 : bank_busy[0]);
        bank_busy_n[1] = (fill &&  bank_sel) ? 1'b1 : (bank_release[1] ? 1'b0 : bank_busy[1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bx_max_l    <= '0;
            by_max_l    <= '0;
            block_x     <= '0;
            block_y     <= '0;
            bank_sel    <= 1'b0;
            bank_filled <= 1'b0;
            filled_id   <= 1'b0;
            bank_busy   <= 2'b00;
            blk_vld     <= 1'b0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            state       <= state_n;
            bx_max_l    <= bx_max_n;
            by_max_l    <= by_max_n;
            block_x     <= block_x_n;
            block_y     <= block_y_n;
            bank_sel    <= bank_sel_n;
            bank_filled <= bank_filled_n;
            filled_id   <= filled_id_n;
            bank_busy   <= bank_busy_n;
            blk_vld     <= (state_n == RUN);
            busy        <= (state_n != IDLE);
            all_done    <= all_done_n;
        end
    end

endmodule

// File: tb/tb_mem_transpose_sched.sv
// Self-checking bench for mem_transpose_sched: a directed vector table plus
// hand-written multi-cycle sequences for stalls, aborts and bank collisions.
module tb_mem_transpose_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] bx_max = '0;
    logic [5:0] by_max = '0;
    logic       blk_vld;
    logic [5:0] block_x;
    logic [5:0] block_y;
    logic       blk_done = 1'b0;
    logic       bank_sel;
    logic       bank_filled;
    logic       filled_id;
    logic [1:0] bank_release = 2'b00;
    logic [1:0] bank_busy;
    logic       busy;
    logic       all_done;

    int errors = 0;
    int checks = 0;

    mem_transpose_sched #(.LOG_B(6)) dut (
        .clk(clk), .rst(rst), .start(start), .bx_max(bx_max), .by_max(by_max),
        .blk_vld(blk_vld), .block_x(block_x), .block_y(block_y), .blk_done(blk_done),
        .bank_sel(bank_sel), .bank_filled(bank_filled), .filled_id(filled_id),
        .bank_release(bank_release), .bank_busy(bank_busy), .busy(busy), .all_done(all_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, start;
        logic [5:0] bx, by;
        logic       done;
        logic [1:0] rel;
        logic       e_vld;
        logic [5:0] e_x, e_y;
        logic       e_sel, e_filled, e_fid;
        logic [1:0] e_bb;
        logic       e_busy, e_ad;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_vld(input string tag);
        int k = 0;
        while (!blk_vld && k < 20) begin
            step();
            k++;
        end
        check({tag, " vld"}, 32'(blk_vld), 32'd1);
    endtask

    // Drives a full job with a generator answering 4 cycles after blk_vld rises and a
    // consumer releasing each bank one cycle after it is filled; checks raster order.
    task automatic run_job(input logic [5:0] bx, input logic [5:0] by, input bit inject, input string tag);
        int         xs[$];
        int         ys[$];
        int         fids[$];
        int         cnt = 0;
        int         n;
        bit         prev_vld = 1'b0;
        bit         done_seen = 1'b0;
        logic [1:0] rel_next = 2'b00;
        n = int'(bx) * int'(by);
        start = 1'b1; bx_max = bx; by_max = by;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
            start = 1'b0;
            blk_done = 1'b0;
            bank_release = rel_next;
            rel_next = bank_filled ? (2'b01 << filled_id) : 2'b00;
            if (bank_filled) fids.push_back(int'(filled_id));
            if (all_done) done_seen = 1'b1;
            if (blk_vld) begin
                if (!prev_vld) begin
                    xs.push_back(int'(block_x));
                    ys.push_back(int'(block_y));
                    cnt = 0;
                    if (inject) begin
                        start = 1'b1; bx_max = 6'd7; by_max = 6'd7;
                    end
                end else begin
                    cnt++;
                end
                if (cnt == 4) blk_done = 1'b1;
            end else if (inject && busy) begin
                blk_done = 1'b1;
            end
            prev_vld = blk_vld;
            if (!done_seen) step();
        end
        check({tag, " finished"}, 32'(done_seen), 32'd1);
        blk_done = 1'b0;
        start = 1'b0;
        step();
        bank_release = 2'b00;
        check({tag, " single all_done"}, 32'(all_done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        check({tag, " banks free"}, 32'(bank_busy), 32'd0);
        check({tag, " block count"}, 32'(xs.size()), 32'(n));
        check({tag, " fill count"}, 32'(fids.size()), 32'(n));
        for (int i = 0; i < n && i < xs.size(); i++) begin
            check($sformatf("%s x[%0d]", tag, i), 32'(xs[i]), 32'(i % int'(bx)));
            check($sformatf("%s y[%0d]", tag, i), 32'(ys[i]), 32'(i / int'(bx)));
        end
        for (int i = 0; i < n && i < fids.size(); i++)
            check($sformatf("%s fid[%0d]", tag, i), 32'(fids[i]), 32'(i % 2));
    endtask

    initial begin
        //          rst   start bx     by     done  rel    vld   x      y      sel   fill  fid   bb     busy  ad
        vecs[0]  = '{1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 6'd2, 6'd1, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 2'b00, 1'b0, 6'd1, 6'd0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b1, 6'd1, 6'd0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 2'b01, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 2'b10, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 6'd0, 6'd5, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};

        step();
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; start = vecs[i].start; bx_max = vecs[i].bx; by_max = vecs[i].by;
            blk_done = vecs[i].done; bank_release = vecs[i].rel;
            step();
            check($sformatf("v%0d blk_vld", i), 32'(blk_vld), 32'(vecs[i].e_vld));
            check($sformatf("v%0d block_x", i), 32'(block_x), 32'(vecs[i].e_x));
            check($sformatf("v%0d block_y", i), 32'(block_y), 32'(vecs[i].e_y));
            check($sformatf("v%0d bank_sel", i), 32'(bank_sel), 32'(vecs[i].e_sel));
            check($sformatf("v%0d bank_filled", i), 32'(bank_filled), 32'(vecs[i].e_filled));
            check($sformatf("v%0d filled_id", i), 32'(filled_id), 32'(vecs[i].e_fid));
            check($sformatf("v%0d bank_busy", i), 32'(bank_busy), 32'(vecs[i].e_bb));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d all_done", i), 32'(all_done), 32'(vecs[i].e_ad));
        end
        rst = 1'b0; start = 1'b0; blk_done = 1'b0; bank_release = 2'b00;

        run_job(6'd3, 6'd2, 1'b0, "job3x2");
        run_job(6'd2, 6'd2, 1'b1, "job2x2_inject");

        // Stall: no releases, both banks fill, scheduler waits for bank 0.
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; bx_max = 6'd2; by_max = 6'd2; step(); start = 1'b0;
        wait_vld("stall b0");
        blk_done = 1'b1; step(); blk_done = 1'b0;
        wait_vld("stall b1");
        check("stall b1 x", 32'(block_x), 32'd1);
        blk_done = 1'b1; step(); blk_done = 1'b0;
        repeat (5) step();
        check("stall vld", 32'(blk_vld), 32'd0);
        check("stall bank_busy", 32'(bank_busy), 32'd3);
        check("stall busy", 32'(busy), 32'd1);
        check("stall next x", 32'(block_x), 32'd0);
        check("stall next y", 32'(block_y), 32'd1);
        bank_release = 2'b01; step(); bank_release = 2'b00;
        check("release r+1 vld", 32'(blk_vld), 32'd0);
        step();
        check("release r+2 vld", 32'(blk_vld), 32'd1);
        check("release r+2 x", 32'(block_x), 32'd0);
        check("release r+2 y", 32'(block_y), 32'd1);
        check("release r+2 sel", 32'(bank_sel), 32'd0);

        // Abort with reset while block (1,0) is running.
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; bx_max = 6'd3; by_max = 6'd1; step(); start = 1'b0;
        wait_vld("abort b0");
        blk_done = 1'b1; step(); blk_done = 1'b0;
        step();
        check("abort pre vld", 32'(blk_vld), 32'd1);
        check("abort pre x", 32'(block_x), 32'd1);
        check("abort pre bb", 32'(bank_busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("abort vld", 32'(blk_vld), 32'd0);
        check("abort x", 32'(block_x), 32'd0);
        check("abort sel", 32'(bank_sel), 32'd0);
        check("abort filled", 32'(bank_filled), 32'd0);
        check("abort bb", 32'(bank_busy), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort all_done", 32'(all_done), 32'd0);
        start = 1'b1; bx_max = 6'd2; by_max = 6'd1; step(); start = 1'b0;
        step();
        check("restart vld", 32'(blk_vld), 32'd1);
        check("restart x", 32'(block_x), 32'd0);
        check("restart y", 32'(block_y), 32'd0);
        check("restart sel", 32'(bank_sel), 32'd0);

        // Finish the 2x1 job leaving bank 1 busy, then collide a fill and a release.
        blk_done = 1'b1; step(); blk_done = 1'b0;
        step();
        blk_done = 1'b1; bank_release = 2'b01; step(); blk_done = 1'b0; bank_release = 2'b00;
        check("pre collide bb", 32'(bank_busy), 32'd2);
        step();
        start = 1'b1; bx_max = 6'd1; by_max = 6'd1; step(); start = 1'b0;
        check("start keeps bb", 32'(bank_busy), 32'd2);
        step();
        check("collide vld", 32'(blk_vld), 32'd1);
        check("collide sel", 32'(bank_sel), 32'd0);
        blk_done = 1'b1; bank_release = 2'b10; step(); blk_done = 1'b0; bank_release = 2'b00;
        check("collide bb", 32'(bank_busy), 32'd1);
        check("collide filled", 32'(bank_filled), 32'd1);
        check("collide fid", 32'(filled_id), 32'd0);
        step();
        check("collide all_done", 32'(all_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
